// File: rtl/sha256_ctrl.sv
// SHA-256 block sequencer: word intake, 64-round compression control, and digest readout.
// Optional SHA-224 mode (IV select, 7-word digest) is enabled by defining SHA256_SHA224_MODE_EN.
module sha256_ctrl #(
    parameter int ROUNDS        = 64,
    parameter int WORDS_PER_BLK = 16
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       msg_start_i,
`ifdef SHA256_SHA224_MODE_EN
    input  logic       mode224_i,
    output logic       init224_o,
`endif
    input  logic       win_valid_i,
    input  logic       win_last_i,
    output logic       win_ready_o,
    output logic       load_en_o,
    output logic       init_hash_o,
    output logic       wv_load_o,
    output logic       round_en_o,
    output logic [5:0] round_idx_o,
    output logic       sched_sel_o,
    output logic       hash_upd_o,
    output logic [2:0] dout_sel_o,
    output logic       dout_valid_o,
    output logic       dout_last_o,
    input  logic       dout_ready_i,
    output logic       busy_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_PREP   = 3'd2;
    localparam logic [2:0] S_ROUND  = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;
    localparam logic [2:0] S_OUT    = 3'd5;

    localparam int             WCW       = $clog2(WORDS_PER_BLK);
    localparam logic [WCW-1:0] WORD_LAST = WCW'(WORDS_PER_BLK - 1);
    localparam logic [5:0]     RND_LAST  = 6'(ROUNDS - 1);
    localparam logic [5:0]     SCHED_T   = 6'd16;

    logic [2:0]     state_q, state_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic [5:0]     round_idx_q, round_idx_d;
    logic [2:0]     out_idx_q, out_idx_d;
    logic           last_q, last_d;
    logic [2:0]     out_last_idx;
    logic           init_hash;

`ifdef SHA256_SHA224_MODE_EN
    logic mode224_q, mode224_d;
    assign out_last_idx = mode224_q ? 3'd6 : 3'd7;
    // IV select qualifies the same gated start pulse as init_hash_o
    assign init224_o    = init_hash_o & mode224_i;
`else
    assign out_last_idx = 3'd7;
`endif

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        round_idx_d  = round_idx_q;
        out_idx_d    = out_idx_q;
        last_d       = last_q;
`ifdef SHA256_SHA224_MODE_EN
        mode224_d    = mode224_q;
`endif
        init_hash    = 1'b0;
        win_ready_o  = 1'b0;
        load_en_o    = 1'b0;
        wv_load_o    = 1'b0;
        round_en_o   = 1'b0;
        sched_sel_o  = 1'b0;
        hash_upd_o   = 1'b0;
        dout_valid_o = 1'b0;
        dout_last_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (msg_start_i) begin
                    init_hash  = 1'b1;
                    word_cnt_d = '0;
                    last_d     = 1'b0;
`ifdef SHA256_SHA224_MODE_EN
                    mode224_d  = mode224_i;
`endif
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                win_ready_o = 1'b1;
                if (win_valid_i) begin
                    load_en_o = 1'b1;
                    if (word_cnt_q == WORD_LAST) begin
                        word_cnt_d = '0;
                        last_d     = win_last_i;
                        state_d    = S_PREP;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            S_PREP: begin
                wv_load_o   = 1'b1;
                round_idx_d = '0;
                state_d     = S_ROUND;
            end
            S_ROUND: begin
                round_en_o  = 1'b1;
                sched_sel_o = (round_idx_q >= SCHED_T);
                if (round_idx_q == RND_LAST) begin
                    round_idx_d = '0;
                    state_d     = S_UPDATE;
                end else begin
                    round_idx_d = round_idx_q + 1'b1;
                end
            end
            S_UPDATE: begin
                hash_upd_o = 1'b1;
                out_idx_d  = '0;
                // Non-final blocks chain straight into the next load, keeping H
                state_d    = last_q ? S_OUT : S_LOAD;
            end
            S_OUT: begin
                dout_valid_o = 1'b1;
                dout_last_o  = (out_idx_q == out_last_idx);
                if (dout_ready_i) begin
                    if (out_idx_q == out_last_idx) begin
                        out_idx_d = '0;
                        last_d    = 1'b0;
                        state_d   = S_IDLE;
                    end else begin
                        out_idx_d = out_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Start pulse is the only output fed straight from an input while IDLE, so hold it off during reset
    assign init_hash_o = init_hash & rst_n_i;
    assign round_idx_o = round_idx_q;
    assign dout_sel_o  = out_idx_q;
    assign busy_o      = (state_q != S_IDLE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            word_cnt_q  <= '0;
            round_idx_q <= '0;
            out_idx_q   <= '0;
            last_q      <= 1'b0;
`ifdef SHA256_SHA224_MODE_EN
            mode224_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            round_idx_q <= round_idx_d;
            out_idx_q   <= out_idx_d;
            last_q      <= last_d;
`ifdef SHA256_SHA224_MODE_EN
            mode224_q   <= mode224_d;
`endif
        end
    end

endmodule
